multi_key_debounce: RTL and testbench
=====================================

# multi_key_debounce

Parametrised N-channel successor to the single-key debouncer. Each channel synchronises a raw mechanical key input, filters contact bounce with a programmable stable-time counter, and reports a clean level plus one-cycle press/release event pulses. Each channel also detects long presses and generates auto-repeat pulses while the key stays held. It sits between board key pads and any control logic that consumes key events, such as LED, menu or counter controllers.

## Interface
- KEY_NUM, 4, number of independent key channels (≥1)
- ACTIVE_LOW, 1, pad polarity: 1 = pressed pad reads 0, 0 = pressed pad reads 1
- DEBOUNCE_CNT, 1_000_000, stable cycles required to accept a new level (20 ms at 50 MHz); ≥2
- LONG_CNT, 50_000_000, cycles from accepted press to long-press pulse (1 s at 50 MHz); ≥2
- REPEAT_CNT, 10_000_000, cycles between auto-repeat pulses after long press; 0 disables repeat

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  asynchronous, active-low reset
- key  input  KEY_NUM  raw asynchronous key pads
- key_value  output  KEY_NUM  debounced state per channel, 1 = pressed, independent of ACTIVE_LOW
- key_press  output  KEY_NUM  one-cycle pulse when key_value goes 0→1
- key_release  output  KEY_NUM  one-cycle pulse when key_value goes 1→0
- key_long  output  KEY_NUM  one-cycle pulse, once per press, after LONG_CNT held cycles
- key_repeat  output  KEY_NUM  one-cycle pulse every REPEAT_CNT cycles after key_long while held

## Operation
- Channels are fully independent; no state is shared between them.
- Synchroniser: two flops per channel, reset to the released pad level (ACTIVE_LOW). Normalised sample p = sync2 XOR ACTIVE_LOW, so 1 = pressed.
- Debounce counter, width $clog2(DEBOUNCE_CNT):
  - If p == key_value, the counter clears to 0.
  - Otherwise, if the counter is below DEBOUNCE_CNT-1, it increments.
  - Otherwise, key_value takes p, the counter clears, and key_press or key_release fires accordingly.
  - Any sample where p returns to key_value restarts the count from 0.
- Hold counter, width $clog2(max(LONG_CNT, REPEAT_CNT)+1):
  - Clears while key_value==0 and increments while key_value==1.
  - On reaching LONG_CNT-1, key_long fires and the counter enters repeat phase.
  - In repeat phase with REPEAT_CNT>0, key_repeat fires each time a REPEAT_CNT-cycle interval completes. With REPEAT_CNT==0 the counter saturates and nothing further fires.
- A release event suppresses key_long and key_repeat on the same edge. No long or repeat pulse follows a release until a new press is accepted.
- key_press and key_release never assert together on a channel. Press, long and repeat never coincide on a channel.
- Asynchronous reset at any point, including mid-count or mid-hold:
  - All outputs and counters go to 0; synchronisers go to the released level.
  - A key still held at reset release must re-qualify with a full debounce count and produces a fresh key_press.

## Timing
- Reset values: key_value, key_press, key_release, key_long, key_repeat all 0.
- All outputs are registered; none are combinational from key.
- Let edge k be the first rising edge sampling the new pad level. sync2 changes at k+1. If the level is held, key_value and the event pulse update at edge k+DEBOUNCE_CNT+1.
- Acceptance threshold: a pad level held for ≥DEBOUNCE_CNT consecutive cycles is accepted. A pulse of ≤DEBOUNCE_CNT-1 cycles is rejected with no output activity.
- With press accepted at edge P:
  - key_long pulses at edge P+LONG_CNT.
  - key_repeat pulses at P+LONG_CNT+m·REPEAT_CNT for m≥1, while key_value stays 1.
- Every pulse output is high for exactly one sys_clk cycle.

## Test plan
Bench parameters: KEY_NUM=2, ACTIVE_LOW=1, DEBOUNCE_CNT=8, LONG_CNT=32, REPEAT_CNT=10, sys_clk period 20 ns.
- Reset: hold sys_rst_n=0 for 50 ns with key=2'b11, then release and wait 20 cycles → every output stays 0 throughout.
- Press with bounce: toggle key[0] every 2 cycles for 10 cycles, then hold 0 → one key_press[0] pulse and key_value[0]=1 exactly 9 edges after the first edge sampling the steady 0; key[1] outputs stay 0.
- Threshold: drive key[1] low for 7 cycles → no activity. Then drive it low for 8 cycles → key_press[1], followed by key_release[1] once the return high is qualified.
- Long/repeat: hold key[0] pressed for 60 cycles after edge P, then release → key_long[0] at P+32, key_repeat[0] at P+42 and P+52, then key_release[0], with no further long/repeat pulses.
- Simultaneous: press both keys on the same edge → key_press=2'b11 on the same edge; release only key[0] → only key_release[0] fires.
- Reset mid-operation: assert sys_rst_n at debounce count 5 while key[0] is held low, deassert 3 cycles later → all outputs 0. key_press[0] then fires a full 9 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/multi_key_debounce.sv
// N-channel key debouncer: sync + stable-time filter, press/release/long/repeat pulses, 1 = pressed.
// Latency: DEBOUNCE_CNT+2 edges from pad change to key_value; no backpressure, pulses are one cycle.
module multi_key_debounce #(
  parameter int KEY_NUM      = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int LONG_CNT     = 50_000_000,
  parameter int REPEAT_CNT   = 10_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_value,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  localparam int DB_W     = $clog2(DEBOUNCE_CNT);
  localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_CNT > 0) ? REPEAT_CNT - 1 : 0);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic              sync1, sync2;
    logic              p;
    logic              accept;
    logic              val_q, press_q, release_q, long_q, repeat_q;
    logic              rep_phase;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    assign p      = sync2 ^ ACTIVE_LOW;
    assign accept = (p != val_q) && (db_cnt == DB_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync1 <= ACTIVE_LOW;
        sync2 <= ACTIVE_LOW;
      end else begin
        sync1 <= key[i];
        sync2 <= sync1;
      end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        db_cnt    <= '0;
        val_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (p == val_q) begin
          db_cnt <= '0;
        end else if (db_cnt != DB_LAST) begin
          db_cnt <= db_cnt + 1'b1;
        end else begin
          db_cnt    <= '0;
          val_q     <= p;
          press_q   <= p;
          release_q <= ~p;
        end
      end
    end

    // A release accepted this edge clears the hold state so no long/repeat can coincide with it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        hold_cnt  <= '0;
        rep_phase <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
        if (!val_q || accept) begin
          hold_cnt  <= '0;
          rep_phase <= 1'b0;
        end else if (!rep_phase) begin
          if (hold_cnt == LONG_LAST) begin
            long_q    <= 1'b1;
            rep_phase <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end else if (REPEAT_CNT > 0) begin
          if (hold_cnt == REP_LAST) begin
            repeat_q <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      end
    end

    assign key_value[i]   = val_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed bench for multi_key_debounce: row table for windowed event counts, hand sequences for edge-exact timing.
module tb_multi_key_debounce;

  logic       sys_clk   = 1'b1;
  logic       sys_rst_n = 1'b0;
  logic [1:0] key       = 2'b11;
  logic [1:0] key_value, key_press, key_release, key_long, key_repeat;

  int n_pass  = 0;
  int n_total = 0;
  int p0, p1, r0, r1, lr;

  always #10 sys_clk = ~sys_clk;

  multi_key_debounce #(
    .KEY_NUM(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CNT(8), .LONG_CNT(32), .REPEAT_CNT(10)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key),
    .key_value(key_value), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  typedef struct {
    logic [1:0] k;
    int         n;
    logic [1:0] val;
    int         press0, press1, rel0, rel1, holdp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic [1:0] k);
    @(negedge sys_clk);
    key = k;
    @(posedge sys_clk);
    #1;
    p0 += int'(key_press[0]);
    p1 += int'(key_press[1]);
    r0 += int'(key_release[0]);
    r1 += int'(key_release[1]);
    lr += int'(key_long[0]) + int'(key_long[1]) + int'(key_repeat[0]) + int'(key_repeat[1]);
  endtask

  function automatic logic [31:0] all_outs();
    return {22'b0, key_value, key_press, key_release, key_long, key_repeat};
  endfunction

  initial begin
    logic [1:0] ev, ep, er, el, erp;

    // key pattern, cycles, final key_value, press0, press1, rel0, rel1, long+repeat total
    vecs[0]  = '{2'b11, 20, 2'b00, 0, 0, 0, 0, 0};
    vecs[1]  = '{2'b01,  7, 2'b00, 0, 0, 0, 0, 0};
    vecs[2]  = '{2'b11, 12, 2'b00, 0, 0, 0, 0, 0};
    vecs[3]  = '{2'b01,  8, 2'b00, 0, 0, 0, 0, 0};
    vecs[4]  = '{2'b11,  2, 2'b10, 0, 1, 0, 0, 0};
    vecs[5]  = '{2'b11, 12, 2'b00, 0, 0, 0, 1, 0};
    vecs[6]  = '{2'b10,  2, 2'b00, 0, 0, 0, 0, 0};
    vecs[7]  = '{2'b11,  2, 2'b00, 0, 0, 0, 0, 0};
    vecs[8]  = '{2'b10,  2, 2'b00, 0, 0, 0, 0, 0};
    vecs[9]  = '{2'b11,  2, 2'b00, 0, 0, 0, 0, 0};
    vecs[10] = '{2'b10,  2, 2'b00, 0, 0, 0, 0, 0};
    vecs[11] = '{2'b11,  2, 2'b00, 0, 0, 0, 0, 0};

    #45;
    check("in_reset_outputs", all_outs(), 32'h0);
    #5 sys_rst_n = 1'b1;

    foreach (vecs[v]) begin
      p0 = 0; p1 = 0; r0 = 0; r1 = 0; lr = 0;
      for (int c = 0; c < vecs[v].n; c++) step(vecs[v].k);
      check($sformatf("row%0d_value", v), {30'b0, key_value}, {30'b0, vecs[v].val});
      check($sformatf("row%0d_events", v),
            {2'b0, 6'(p0), 6'(p1), 6'(r0), 6'(r1), 6'(lr)},
            {2'b0, 6'(vecs[v].press0), 6'(vecs[v].press1), 6'(vecs[v].rel0),
             6'(vecs[v].rel1), 6'(vecs[v].holdp)});
    end

    // Steady press on key[0] after the bounce; accepted 9 edges after the first sampling edge.
    for (int i = 0; i <= 9; i++) begin
      step(2'b10);
      ev = (i >= 9) ? 2'b01 : 2'b00;
      ep = (i == 9) ? 2'b01 : 2'b00;
      check($sformatf("press0_edge%0d", i), {28'b0, key_value, key_press}, {28'b0, ev, ep});
    end

    // Held through long and two repeats; pad released at P+51 so release lands at P+60.
    for (int e = 1; e <= 90; e++) begin
      step((e <= 50) ? 2'b10 : 2'b11);
      ev  = (e < 60) ? 2'b01 : 2'b00;
      er  = (e == 60) ? 2'b01 : 2'b00;
      el  = (e == 32) ? 2'b01 : 2'b00;
      erp = (e == 42 || e == 52) ? 2'b01 : 2'b00;
      check($sformatf("hold0_P+%0d", e), all_outs(), {22'b0, ev, 2'b00, er, el, erp});
    end

    // Both keys pressed on the same edge.
    for (int i = 0; i <= 9; i++) begin
      step(2'b00);
      ev = (i >= 9) ? 2'b11 : 2'b00;
      ep = (i == 9) ? 2'b11 : 2'b00;
      check($sformatf("both_press_edge%0d", i), {28'b0, key_value, key_press}, {28'b0, ev, ep});
    end
    // Release only key[0].
    for (int i = 0; i <= 9; i++) begin
      step(2'b01);
      ev = (i >= 9) ? 2'b10 : 2'b11;
      er = (i == 9) ? 2'b01 : 2'b00;
      check($sformatf("rel0_only_edge%0d", i), {26'b0, key_value, key_press, key_release},
            {26'b0, ev, 2'b00, er});
    end
    for (int i = 0; i < 20; i++) step(2'b11);
    check("idle_after_both", {30'b0, key_value}, 32'h0);

    // Reset mid-debounce at count 5 with key[0] held, then full re-qualification.
    for (int i = 0; i <= 6; i++) step(2'b10);
    sys_rst_n = 1'b0;
    #1 check("midreset_outputs", all_outs(), 32'h0);
    for (int i = 0; i < 3; i++) step(2'b10);
    check("midreset_held_outputs", all_outs(), 32'h0);
    #4 sys_rst_n = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      step(2'b10);
      ev = (j >= 9) ? 2'b01 : 2'b00;
      ep = (j == 9) ? 2'b01 : 2'b00;
      check($sformatf("post_reset_press_edge%0d", j), {28'b0, key_value, key_press},
            {28'b0, ev, ep});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
